// File: rtl/image_io_ctrl_if.sv
// Port-0 memory bus plus the pixel streams and core handshake of image_io_ctrl.
// master: the controller side; slave: stream source/sink, cores and memory.
interface image_io_ctrl_if #(
  parameter int A_W = 5,
  parameter int D_W = 1
);
  logic           GO;
  logic [D_W-1:0] S_DATA;
  logic           S_VALID;
  logic           S_READY;
  logic [D_W-1:0] M_DATA;
  logic           M_VALID;
  logic           M_READY;
  logic           M_LAST;
  logic           START_OUT;
  logic           DONE_IN;
  logic           BUSY;
  logic [A_W-1:0] A_0;
  logic [D_W-1:0] DI_0;
  logic           WE_0;
  logic [D_W-1:0] DQ_0;

  modport master (
    input  GO, S_DATA, S_VALID, M_READY, DONE_IN, DQ_0,
    output S_READY, M_DATA, M_VALID, M_LAST, START_OUT, BUSY, A_0, DI_0, WE_0
  );

  modport slave (
    output GO, S_DATA, S_VALID, M_READY, DONE_IN, DQ_0,
    input  S_READY, M_DATA, M_VALID, M_LAST, START_OUT, BUSY, A_0, DI_0, WE_0
  );
endinterface

// File: rtl/image_io_ctrl.sv
// image_io_ctrl: loads a DEPTH-pixel image into memory port 0, starts the
// cores, waits for DONE_IN, then streams the processed image back out.
// DEPTH must equal 2**A_W so the counters wrap exactly at the image end.
// Optional feature: define IMG_IO_PARITY_EN to add PAR_IN / PAR_OUT parity ports.
module image_io_ctrl #(
  parameter int A_W   = 5,
  parameter int D_W   = 1,
  parameter int DEPTH = 32
) (
  input  logic           CLK,
  input  logic           RST,
  image_io_ctrl_if.master bus
`ifdef IMG_IO_PARITY_EN
  ,
  output logic           PAR_IN,
  output logic           PAR_OUT
`endif
);

  localparam logic [A_W-1:0] LAST = A_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;

  state_t         state_reg, state_next;
  logic [A_W-1:0] wr_cnt_reg, wr_cnt_next;
  logic [A_W-1:0] rd_cnt_reg, rd_cnt_next;
  logic           first_reg, first_next;   // marks the first RUN cycle
  logic           in_beat;
  logic           out_beat;

  // State and counter registers; reset wins over every other event.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      wr_cnt_reg <= '0;
      rd_cnt_reg <= '0;
      first_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_cnt_reg <= wr_cnt_next;
      rd_cnt_reg <= rd_cnt_next;
      first_reg  <= first_next;
    end
  end

  // Next-state logic and output decode. Handshake strobes are masked while
  // RST is high so no beat, write or start pulse lands in a reset cycle.
  always_comb begin
    state_next    = state_reg;
    wr_cnt_next   = wr_cnt_reg;
    rd_cnt_next   = rd_cnt_reg;
    first_next    = 1'b0;
    in_beat       = 1'b0;
    out_beat      = 1'b0;
    bus.S_READY   = 1'b0;
    bus.M_DATA    = '0;
    bus.M_VALID   = 1'b0;
    bus.M_LAST    = 1'b0;
    bus.START_OUT = 1'b0;
    bus.A_0       = '0;
    bus.DI_0      = bus.S_DATA;
    bus.WE_0      = 1'b0;
    bus.BUSY      = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        wr_cnt_next = '0;
        rd_cnt_next = '0;
        if (bus.GO) state_next = LOAD;
      end

      LOAD: begin
        bus.S_READY = ~RST;
        bus.A_0     = wr_cnt_reg;
        bus.WE_0    = bus.S_VALID & ~RST;
        in_beat     = bus.S_VALID;
        if (in_beat) begin
          wr_cnt_next = wr_cnt_reg + 1'b1;
          if (wr_cnt_reg == LAST) begin
            state_next = RUN;
            first_next = 1'b1;
          end
        end
      end

      RUN: begin
        bus.START_OUT = first_reg & ~RST;
        if (bus.DONE_IN) state_next = UNLOAD;
      end

      UNLOAD: begin
        bus.A_0     = rd_cnt_reg;
        bus.M_DATA  = bus.DQ_0;
        bus.M_VALID = ~RST;
        bus.M_LAST  = (rd_cnt_reg == LAST);
        out_beat    = bus.M_READY;
        if (out_beat) begin
          rd_cnt_next = rd_cnt_reg + 1'b1;
          if (rd_cnt_reg == LAST) state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

`ifdef IMG_IO_PARITY_EN
  logic par_in_reg;
  logic par_out_reg;

  // Running parities: input side restarts on GO, output side on UNLOAD entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_in_reg  <= 1'b0;
      par_out_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && bus.GO)
        par_in_reg <= 1'b0;
      else if (state_reg == LOAD && in_beat)
        par_in_reg <= par_in_reg ^ (^bus.S_DATA);

      if (state_reg == RUN && bus.DONE_IN)
        par_out_reg <= 1'b0;
      else if (state_reg == UNLOAD && out_beat)
        par_out_reg <= par_out_reg ^ (^bus.DQ_0);
    end
  end

  assign PAR_IN  = par_in_reg;
  assign PAR_OUT = par_out_reg;
`endif

endmodule

// File: tb/tb_image_io_ctrl.sv
// Self-checking bench for image_io_ctrl: directed passes with randomized
// images, stalls, backpressure, ignored inputs and a mid-load reset.
module tb_image_io_ctrl;

  localparam int A_W   = 5;
  localparam int D_W   = 1;
  localparam int DEPTH = 32;

  logic clk;
  logic rst;

  image_io_ctrl_if #(.A_W(A_W), .D_W(D_W)) bus ();

`ifdef IMG_IO_PARITY_EN
  logic par_in;
  logic par_out;
`endif

  image_io_ctrl #(.A_W(A_W), .D_W(D_W), .DEPTH(DEPTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
`ifdef IMG_IO_PARITY_EN
    ,
    .PAR_IN  (par_in),
    .PAR_OUT (par_out)
`endif
  );

  // Memory port 0 model: synchronous write, asynchronous read.
  logic [D_W-1:0] mem [DEPTH];
  int we_cnt = 0;

  assign bus.DQ_0 = mem[bus.A_0];

  always @(posedge clk) begin
    if (bus.WE_0 === 1'b1) begin
      mem[bus.A_0] <= bus.DI_0;
      we_cnt <= we_cnt + 1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_vec();
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = mem[i][0];
    return v;
  endfunction

  // One full GO/LOAD/RUN/UNLOAD pass.
  // vmode: 0 S_VALID always 1, 1 pattern 1,0,0,1, 2 random.
  // rmode: 0 M_READY always 1, 1 held low 5 cycles at beat 7, 2 random.
  task automatic do_pass(input logic [31:0] img, input int vmode, input int dly, input int rmode);
    int idx, cyc, c, beat, hold, we0;
    logic vld, rdy, done;
    // GO in IDLE
    bus.GO = 1'b1;
    @(negedge clk);
    check("idle_busy", bus.BUSY, 0);
    advance();
    bus.GO = 1'b0;
    // LOAD
    we0 = we_cnt;
    idx = 0;
    cyc = 0;
    while (idx < DEPTH && cyc < 400) begin
      if (vmode == 0) vld = 1'b1;
      else if (vmode == 1) vld = (cyc % 4 == 0) || (cyc % 4 == 3);
      else vld = 1'($urandom_range(0, 1));
      bus.S_VALID = vld;
      bus.S_DATA  = vld ? img[idx] : 1'($urandom_range(0, 1));
      bus.GO      = 1'($urandom_range(0, 1));
      bus.DONE_IN = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cyc == 0 || vld) begin
        check("load_ready", bus.S_READY, 1);
        check("load_addr", bus.A_0, idx);
      end
      check("load_we", bus.WE_0, vld);
      if (vld) check("load_di", bus.DI_0, img[idx]);
      check("load_start", bus.START_OUT, 0);
      if (vld) idx++;
      cyc++;
      advance();
    end
    bus.S_VALID = 1'b0;
    bus.GO      = 1'b0;
    bus.DONE_IN = 1'b0;
    check("load_beats", idx, DEPTH);
    if (vmode == 0) check("load_cycles", cyc, DEPTH);
    check("we_pulses", we_cnt - we0, DEPTH);
    check("mem_image", mem_vec(), img);
    // RUN
    c = 0;
    done = 1'b0;
    while (!done && c < 400) begin
      bus.DONE_IN = (c >= dly);
      bus.GO      = 1'($urandom_range(0, 1));
      bus.M_READY = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == 0 || c == dly) begin
        check("run_start", bus.START_OUT, (c == 0));
        check("run_sready", bus.S_READY, 0);
        check("run_mvalid", bus.M_VALID, 0);
        check("run_busy", bus.BUSY, 1);
      end
      check("run_we", bus.WE_0, 0);
`ifdef IMG_IO_PARITY_EN
      if (c == 0) check("par_in", par_in, ^img);
`endif
      done = bus.DONE_IN;
      c++;
      advance();
    end
    bus.DONE_IN = 1'b0;
    check("run_len", c, dly + 1);
    // UNLOAD
    beat = 0;
    cyc = 0;
    hold = 0;
    while (beat < DEPTH && cyc < 600) begin
      if (rmode == 0) rdy = 1'b1;
      else if (rmode == 1) rdy = !(beat == 7 && hold < 5);
      else rdy = 1'($urandom_range(0, 1));
      if (rmode == 1 && !rdy) hold++;
      bus.M_READY = rdy;
      bus.GO      = 1'($urandom_range(0, 1));
      bus.DONE_IN = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("out_valid", bus.M_VALID, 1);
      check("out_addr", bus.A_0, beat);
      check("out_data", bus.M_DATA, img[beat]);
      check("out_last", bus.M_LAST, (beat == DEPTH - 1));
      if (rdy) begin
        check("out_we", bus.WE_0, 0);
      end
      if (rdy) beat++;
      cyc++;
      advance();
    end
    bus.M_READY = 1'b0;
    bus.GO      = 1'b0;
    bus.DONE_IN = 1'b0;
    check("out_beats", beat, DEPTH);
    if (rmode == 0) check("out_cycles", cyc, DEPTH);
    if (rmode == 1) check("bp_cycles", cyc, DEPTH + 5);
    @(negedge clk);
    check("end_busy", bus.BUSY, 0);
    check("end_mvalid", bus.M_VALID, 0);
`ifdef IMG_IO_PARITY_EN
    check("par_out", par_out, ^img);
`endif
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_img, new_img;
    int we0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst = 1'b1;
    bus.GO = 1'b0;
    bus.S_DATA = '0;
    bus.S_VALID = 1'b0;
    bus.M_READY = 1'b0;
    bus.DONE_IN = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      advance();
      @(negedge clk);
      check("rst_busy", bus.BUSY, 0);
      check("rst_sready", bus.S_READY, 0);
      check("rst_mvalid", bus.M_VALID, 0);
      check("rst_mlast", bus.M_LAST, 0);
      check("rst_start", bus.START_OUT, 0);
      check("rst_we", bus.WE_0, 0);
      check("rst_addr", bus.A_0, 0);
`ifdef IMG_IO_PARITY_EN
      check("rst_par_in", par_in, 0);
      check("rst_par_out", par_out, 0);
`endif
    end
    advance();
    rst = 1'b0;

    // DONE_IN in IDLE is ignored
    bus.DONE_IN = 1'b1;
    advance();
    advance();
    bus.DONE_IN = 1'b0;
    @(negedge clk);
    check("idle_done_busy", bus.BUSY, 0);
    check("idle_done_mvalid", bus.M_VALID, 0);
    advance();

    do_pass(32'h5555F0F0, 0, 4, 0);
    do_pass($urandom, 1, 0, 1);
    do_pass($urandom, 2, $urandom_range(0, 6), 2);

    // Reset in the middle of LOAD at wr_cnt=12
    old_img = mem_vec();
    new_img = $urandom;
    bus.GO = 1'b1;
    advance();
    bus.GO = 1'b0;
    we0 = we_cnt;
    for (int i = 0; i < 12; i++) begin
      bus.S_VALID = 1'b1;
      bus.S_DATA  = new_img[i];
      advance();
    end
    rst = 1'b1;
    bus.S_VALID = 1'b1;
    bus.S_DATA  = ~new_img[12];
    bus.GO = 1'b1;
    bus.DONE_IN = 1'b1;
    @(negedge clk);
    check("rstmid_we", bus.WE_0, 0);
    advance();
    rst = 1'b0;
    bus.S_VALID = 1'b0;
    bus.GO = 1'b0;
    bus.DONE_IN = 1'b0;
    @(negedge clk);
    check("rstmid_busy", bus.BUSY, 0);
    check("rstmid_sready", bus.S_READY, 0);
    check("rstmid_start", bus.START_OUT, 0);
    check("rstmid_we_pulses", we_cnt - we0, 12);
    check("rstmid_mem", mem_vec(), {old_img[31:12], new_img[11:0]});
    advance();

    do_pass($urandom, 2, $urandom_range(0, 3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
